// File: rtl/paddsb_seq.sv
// paddsb_seq: sequential 16-bit add with four independent signed 4-bit
// saturating lanes, computed by one shared lane over four RUN cycles,
// least significant nibble first.
module paddsb_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Sum,
    output logic [3:0]  sat
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg;
    logic [1:0]  cnt_reg;
    logic [15:0] a_reg;
    logic [15:0] b_reg;
    logic [11:0] stage_sum_reg;
    logic [2:0]  stage_sat_reg;
    logic        busy_reg;
    logic        done_reg;
    logic [15:0] sum_reg;
    logic [3:0]  sat_reg;

    // Captured operands split into nibbles so the shared lane can select one.
    logic [3:0] a_nib [4];
    logic [3:0] b_nib [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign a_nib[gi] = a_reg[4*gi +: 4];
            assign b_nib[gi] = b_reg[4*gi +: 4];
        end
    endgenerate

    logic [3:0] lane_a;
    logic [3:0] lane_b;
    logic [3:0] lane_raw;
    logic [3:0] lane_res;
    logic       lane_sat;

    // Shared saturating lane: wraps to the signed limit when two same-sign
    // inputs produce a result of the opposite sign.
    always_comb begin
        lane_a   = a_nib[cnt_reg];
        lane_b   = b_nib[cnt_reg];
        lane_raw = lane_a + lane_b;
        lane_res = lane_raw;
        lane_sat = 1'b0;
        if (!lane_a[3] && !lane_b[3] && lane_raw[3]) begin
            lane_res = 4'b0111;
            lane_sat = 1'b1;
        end else if (lane_a[3] && lane_b[3] && !lane_raw[3]) begin
            lane_res = 4'b1000;
            lane_sat = 1'b1;
        end
    end

    // Control FSM, staging and result registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 2'd0;
            a_reg         <= 16'h0000;
            b_reg         <= 16'h0000;
            stage_sum_reg <= 12'h000;
            stage_sat_reg <= 3'b000;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            sum_reg       <= 16'h0000;
            sat_reg       <= 4'b0000;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !abort) begin
                        a_reg     <= A;
                        b_reg     <= B;
                        cnt_reg   <= 2'd0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        cnt_reg   <= 2'd0;
                        busy_reg  <= 1'b0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + 2'd1;
                        case (cnt_reg)
                            2'd0: begin
                                stage_sum_reg[3:0] <= lane_res;
                                stage_sat_reg[0]   <= lane_sat;
                            end
                            2'd1: begin
                                stage_sum_reg[7:4] <= lane_res;
                                stage_sat_reg[1]   <= lane_sat;
                            end
                            2'd2: begin
                                stage_sum_reg[11:8] <= lane_res;
                                stage_sat_reg[2]    <= lane_sat;
                            end
                            default: begin
                                sum_reg   <= {lane_res, stage_sum_reg};
                                sat_reg   <= {lane_sat, stage_sat_reg};
                                done_reg  <= 1'b1;
                                busy_reg  <= 1'b0;
                                state_reg <= IDLE;
                            end
                        endcase
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign Sum  = sum_reg;
    assign sat  = sat_reg;

endmodule

// File: tb/tb_paddsb_seq.sv
// Directed bench for paddsb_seq: hand-computed vectors, back-to-back,
// ignored start while busy, abort, reset mid-operation, start+abort in IDLE.
module tb_paddsb_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Sum;
    logic [3:0]  sat;

    int nvec = 0;
    int nerr = 0;

    paddsb_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .abort (abort),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .Sum   (Sum),
        .sat   (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation, scramble operands while busy (optionally with a
    // stray start), and stop in the done cycle after checking the result.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] esum, input logic [3:0] esat,
                         input bit stray_start);
        A = a; B = b; start = 1'b1;
        step();
        start = 1'b0;
        A = ~a; B = ~b;
        for (int i = 0; i < 4; i++) begin
            check("busy_run", busy, 1);
            check("done_run", done, 0);
            start = (stray_start && i == 1);
            if (start) begin
                A = 16'hFFFF; B = 16'h7777;
            end
            step();
        end
        start = 1'b0;
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        check("sum", Sum, esum);
        check("sat", sat, esat);
        $display("op A=%04h B=%04h -> Sum=%04h sat=%04b (expect %04h %04b)",
                 a, b, Sum, sat, esum, esat);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; A = 16'h0; B = 16'h0;
        step();
        step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", Sum, 16'h0000);
        check("rst_sat", sat, 4'b0000);
        $display("reset applied");
        rst = 1'b0;
        step();

        // Plain vectors
        do_op(16'h1234, 16'h1111, 16'h2345, 4'b0000, 0);
        step();
        check("done_clear", done, 0);
        do_op(16'h783F, 16'h1821, 16'h7850, 4'b1100, 0);
        step();
        do_op(16'h8080, 16'h8080, 16'h8080, 4'b1010, 0);
        step();
        do_op(16'h7777, 16'h0101, 16'h7777, 4'b0101, 0);
        step();
        do_op(16'hF0F0, 16'hF0F0, 16'hE0E0, 4'b0000, 0);
        step();
        do_op(16'h9999, 16'h9999, 16'h8888, 4'b1111, 0);
        step();

        // Back-to-back: second start issued in the done cycle of the first
        do_op(16'h1234, 16'h1111, 16'h2345, 4'b0000, 0);
        do_op(16'h0001, 16'h0001, 16'h0002, 4'b0000, 1);
        for (int i = 0; i < 6; i++) begin
            step();
            check("no_queued_done", done, 0);
            check("no_queued_busy", busy, 0);
        end
        check("hold_sum", Sum, 16'h0002);
        $display("back-to-back with stray start complete");

        // Abort on the 2nd busy cycle
        do_op(16'h1234, 16'h1111, 16'h2345, 4'b0000, 0);
        step();
        A = 16'h1111; B = 16'h1111; start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("abort_busy_pre", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("abort_no_done", done, 0);
        end
        check("abort_sum", Sum, 16'h2345);
        check("abort_sat", sat, 4'b0000);
        $display("abort -> Sum=%04h", Sum);

        // Reset on the 3rd busy cycle
        A = 16'h783F; B = 16'h1821; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("rst_mid_busy_pre", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        check("rst_mid_sum", Sum, 16'h0000);
        check("rst_mid_sat", sat, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rst_mid_no_done", done, 0);
        end
        $display("reset mid-op -> Sum=%04h sat=%04b", Sum, sat);
        do_op(16'h783F, 16'h1821, 16'h7850, 4'b1100, 0);
        step();

        // start and abort together in IDLE
        A = 16'h1111; B = 16'h1111; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("sa_busy", busy, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("sa_no_done", done, 0);
            check("sa_busy_hold", busy, 0);
        end
        check("sa_sum", Sum, 16'h7850);
        $display("start+abort in idle -> busy=%0b Sum=%04h", busy, Sum);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
